// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - Default widths and sequential PC increment used by fetch_stage, ifid_reg and fetch_stage_if.
//   - FSM state type of the fetch controller.
package fetch_pkg;

  localparam int unsigned DefaultAddrW  = 16;
  localparam int unsigned DefaultInstrW = 16;
  localparam int unsigned DefaultPcStep = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request (fetch side -> memory)
//   imem_addr  : fetch address (fetch side -> memory)
//   imem_ack   : read data valid this cycle (memory -> fetch side)
//   imem_rdata : fetched instruction (memory -> fetch side)
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = fetch_pkg::DefaultAddrW,
  parameter int unsigned INSTR_W = fetch_pkg::DefaultInstrW
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears everything to 0)
//   load_i       : capture instr_i/pc_i and mark valid
//   clear_i      : drop valid; payload is left as-is
//   instr_i/pc_i : payload to capture
//   valid_o/instr_o/pc_o : register contents
// Priority: reset > clear > load > hold.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned INSTR_W = DefaultInstrW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests instructions at the current PC, loads them into the IF/ID
// register, computes the next PC, and handles decode stalls and branch redirects.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   pc / next_pc     : current PC in, combinational next PC out to the PC register
//   imem             : fetch_stage_if.master (imem_req, imem_addr, imem_ack, imem_rdata)
//   stall            : decode cannot accept; the fetched instruction is held
//   redirect/_target : taken branch/jump; overrides stall and ack, flushes IF/ID
//   ifid_valid/_instr/_pc : IF/ID register contents
//   fetch_fault      : sticky misaligned-fetch flag
// Optional feature, macro FETCH_ALIGN_CHECK_EN:
//   defined   -> odd PC in REQ suppresses the request, holds the PC and sets fetch_fault until
//                redirect or reset; imem_addr = pc.
//   undefined -> imem_addr has bit 0 forced low and fetch_fault is tied 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned INSTR_W = DefaultInstrW,
  parameter int unsigned PC_STEP = DefaultPcStep
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next_pc,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               fetch_fault
);

  fetch_state_e state_q, state_d;
  logic         misaligned;
  logic         req;
  logic         advance;
  logic         ifid_load;
  logic         ifid_clear;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned     = pc[0];
  assign imem.imem_addr = pc;
`else
  assign misaligned     = 1'b0;
  assign imem.imem_addr = {pc[ADDR_W-1:1], 1'b0};
`endif

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    advance    = 1'b0;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (misaligned) begin
          // No request goes out, so nothing can be loaded this cycle.
          ifid_clear = 1'b1;
        end else begin
          req = 1'b1;
          if (imem.imem_ack) begin
            advance   = 1'b1;
            ifid_load = 1'b1;
            if (stall) begin
              state_d = StHold;
            end
          end else begin
            ifid_clear = 1'b1;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A taken branch discards whatever arrived this cycle and restarts fetching.
    if (redirect) begin
      state_d    = StReq;
      ifid_load  = 1'b0;
      ifid_clear = 1'b1;
    end

    if (reset) begin
      next_pc = '0;
    end else if (redirect) begin
      next_pc = redirect_target;
    end else if (advance) begin
      next_pc = pc + ADDR_W'(PC_STEP);
    end else begin
      next_pc = pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign imem.imem_req = req & ~reset;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (redirect) begin
      fault_d = 1'b0;
    end else if ((state_q == StReq) && misaligned) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clock   (clock),
    .reset   (reset),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .instr_i (imem.imem_rdata),
    .pc_i    (pc),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model compared on every falling edge,
// plus directed vectors with literal expectations.
module tb_fetch_stage;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        fetch_fault;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) imem_bus ();

  fetch_stage #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .PC_STEP (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .next_pc         (next_pc),
    .imem            (imem_bus),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .fetch_fault     (fetch_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model: what the fetch stage holds, in terms of "has it started fetching", "is it frozen
  // waiting on decode", and the IF/ID contents it must show.
  bit        m_started = 1'b0;
  bit        m_frozen  = 1'b0;
  bit        m_valid   = 1'b0;
  bit        m_fault   = 1'b0;
  bit [15:0] m_instr   = '0;
  bit [15:0] m_pc      = '0;

  always @(negedge clock) begin : model_cmp
    bit        bad_pc;
    bit        exp_req;
    bit [15:0] exp_np;
    bit [15:0] exp_addr;

    bad_pc   = AlignChk && pc[0];
    exp_req  = !reset && m_started && !m_frozen && !bad_pc;
    exp_addr = AlignChk ? pc : (pc & 16'hFFFE);
    if (reset)                                exp_np = 16'h0000;
    else if (redirect)                        exp_np = redirect_target;
    else if (exp_req && imem_bus.imem_ack)    exp_np = pc + 16'd2;
    else                                      exp_np = pc;

    chk("m_imem_req",   imem_bus.imem_req, exp_req);
    chk("m_next_pc",    next_pc, exp_np);
    chk("m_ifid_valid", ifid_valid, m_valid);
    chk("m_fault",      fetch_fault, m_fault);
    if (exp_req) chk("m_imem_addr", imem_bus.imem_addr, exp_addr);
    if (m_valid) begin
      chk("m_ifid_instr", ifid_instr, m_instr);
      chk("m_ifid_pc",    ifid_pc, m_pc);
    end

    // What the next rising edge must leave behind.
    if (reset) begin
      m_started = 1'b0; m_frozen = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
      m_instr = '0; m_pc = '0;
    end else if (redirect) begin
      m_started = 1'b1; m_frozen = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_frozen) begin
      if (!stall) m_frozen = 1'b0;
    end else if (bad_pc) begin
      m_fault = 1'b1; m_valid = 1'b0;
    end else if (imem_bus.imem_ack) begin
      m_valid = 1'b1; m_instr = imem_bus.imem_rdata; m_pc = pc; m_frozen = stall;
    end else begin
      m_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = '0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;

    // Reset held three cycles.
    repeat (3) step();
    #1;
    chk("rst_next_pc", next_pc, 16'h0000);
    chk("rst_req",     imem_bus.imem_req, 1'b0);
    chk("rst_addr",    imem_bus.imem_addr, 16'h0000);
    chk("rst_valid",   ifid_valid, 1'b0);
    chk("rst_instr",   ifid_instr, 16'h0000);
    chk("rst_ifid_pc", ifid_pc, 16'h0000);
    chk("rst_fault",   fetch_fault, 1'b0);

    // IDLE for one cycle, then REQ.
    reset = 1'b0;
    #1 chk("idle_req", imem_bus.imem_req, 1'b0);
    step();
    #1 chk("req_up", imem_bus.imem_req, 1'b1);

    // Single fetch.
    pc = 16'h0004; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'hA1B2;
    #1 chk("fetch_next_pc", next_pc, 16'h0006);
    step();
    imem_bus.imem_ack = 1'b0;
    #1;
    chk("fetch_instr", ifid_instr, 16'hA1B2);
    chk("fetch_pc",    ifid_pc, 16'h0004);
    chk("fetch_valid", ifid_valid, 1'b1);

    // Sustained one-per-cycle fetch.
    for (int i = 0; i < 4; i++) begin
      pc = 16'h0010 + 16'(2 * i);
      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h1000 + 16'(i);
      step();
      #1 chk("seq_valid", ifid_valid, 1'b1);
    end
    imem_bus.imem_ack = 1'b0;
    #1;
    chk("seq_last_pc",    ifid_pc, 16'h0016);
    chk("seq_last_instr", ifid_instr, 16'h1003);

    // Ack under stall: capture, then hold three cycles.
    pc = 16'h0020; imem_bus.imem_ack = 1'b1; stall = 1'b1; imem_bus.imem_rdata = 16'h5555;
    #1 chk("stall_next_pc", next_pc, 16'h0022);
    step();
    pc = 16'h0022; imem_bus.imem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_req",     imem_bus.imem_req, 1'b0);
      chk("hold_next_pc", next_pc, 16'h0022);
      chk("hold_instr",   ifid_instr, 16'h5555);
      chk("hold_valid",   ifid_valid, 1'b1);
      step();
    end
    stall = 1'b0; imem_bus.imem_ack = 1'b0;
    #1 chk("release_req", imem_bus.imem_req, 1'b0);
    step();
    #1;
    chk("resume_req",  imem_bus.imem_req, 1'b1);
    chk("resume_addr", imem_bus.imem_addr, 16'h0022);

    // Redirect beats a simultaneous ack and stall.
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h7777;
    step();
    pc = 16'h0024; imem_bus.imem_rdata = 16'hBEEF; stall = 1'b1;
    redirect = 1'b1; redirect_target = 16'h0100;
    #1 chk("redir_next_pc", next_pc, 16'h0100);
    step();
    redirect = 1'b0; imem_bus.imem_ack = 1'b0; stall = 1'b0; pc = 16'h0100;
    #1;
    chk("redir_valid", ifid_valid, 1'b0);
    chk("redir_req",   imem_bus.imem_req, 1'b1);

    // PC wrap.
    pc = 16'hFFFE; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h1234;
    #1 chk("wrap_next_pc", next_pc, 16'h0000);
    step();
    imem_bus.imem_ack = 1'b0;

    // Misaligned PC.
`ifdef FETCH_ALIGN_CHECK_EN
    pc = 16'h0003; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h3333;
    #1;
    chk("mis_req",     imem_bus.imem_req, 1'b0);
    chk("mis_next_pc", next_pc, 16'h0003);
    step();
    #1;
    chk("mis_fault", fetch_fault, 1'b1);
    chk("mis_valid", ifid_valid, 1'b0);
    step();
    #1 chk("mis_sticky", fetch_fault, 1'b1);
    redirect = 1'b1; redirect_target = 16'h0010;
    #1 chk("mis_redir_pc", next_pc, 16'h0010);
    step();
    redirect = 1'b0; imem_bus.imem_ack = 1'b0; pc = 16'h0010;
    #1;
    chk("mis_clear", fetch_fault, 1'b0);
    chk("mis_req_back", imem_bus.imem_req, 1'b1);
`else
    pc = 16'h0003;
    #1;
    chk("mis_addr",  imem_bus.imem_addr, 16'h0002);
    chk("mis_fault", fetch_fault, 1'b0);
    chk("mis_req",   imem_bus.imem_req, 1'b1);
    step();
    pc = 16'h0010;
`endif

    // Redirect out of HOLD.
    pc = 16'h0040; imem_bus.imem_ack = 1'b1; stall = 1'b1; imem_bus.imem_rdata = 16'h4444;
    step();
    imem_bus.imem_ack = 1'b0; redirect = 1'b1; redirect_target = 16'h0080;
    #1;
    chk("hredir_next_pc", next_pc, 16'h0080);
    chk("hredir_req",     imem_bus.imem_req, 1'b0);
    step();
    redirect = 1'b0; stall = 1'b0; pc = 16'h0080;
    #1;
    chk("hredir_valid", ifid_valid, 1'b0);
    chk("hredir_reqon", imem_bus.imem_req, 1'b1);

    // Reset in the middle of a request, with an ack present.
    pc = 16'h0050; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h9999; reset = 1'b1;
    #1;
    chk("mrst_next_pc", next_pc, 16'h0000);
    chk("mrst_req",     imem_bus.imem_req, 1'b0);
    step();
    reset = 1'b0; imem_bus.imem_ack = 1'b0;
    #1;
    chk("mrst_valid",   ifid_valid, 1'b0);
    chk("mrst_instr",   ifid_instr, 16'h0000);
    chk("mrst_ifid_pc", ifid_pc, 16'h0000);
    chk("mrst_idle",    imem_bus.imem_req, 1'b0);
    step();
    #1 chk("mrst_req_up", imem_bus.imem_req, 1'b1);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PC/address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter PC_STEP, default 2, sequential PC increment.
REQ-004 SHALL use one clock; reset is synchronous and active-high; all state updates on rising edge of clock.
REQ-005 SHALL have ports (name direction width meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- pc  in  ADDR_W  current PC from PC register
- next_pc  out  ADDR_W  value fed to PC register input
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- stall  in  1  downstream (decode) cannot accept
- redirect  in  1  branch/jump taken
- redirect_target  in  ADDR_W  branch/jump target
- ifid_valid  out  1  IF/ID register holds valid instruction
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc  out  ADDR_W  PC of ifid_instr
- fetch_fault  out  1  misaligned-fetch flag

Function
REQ-006 SHALL implement FSM states IDLE, REQ, HOLD; encoding from shared package.
REQ-007 IDLE: imem_req=0; next cycle -> REQ.
REQ-008 REQ: imem_req=1, imem_addr=pc; imem_ack=1 and stall=0 -> load IF/ID (ifid_instr=imem_rdata, ifid_pc=pc, ifid_valid=1), stay REQ; imem_ack=1 and stall=1 -> capture into IF/ID, go HOLD; imem_ack=0 -> stay REQ, ifid_valid=0.
REQ-009 HOLD: imem_req=0, IF/ID contents frozen, ifid_valid=1; stall=0 -> REQ next cycle.
REQ-010 next_pc SHALL be combinational: redirect=1 -> redirect_target; else REQ with imem_ack=1 -> pc+PC_STEP; else pc (hold).
REQ-011 pc+PC_STEP SHALL wrap modulo 2^ADDR_W (0xFFFE+2 -> 0x0000).
REQ-012 redirect=1 in any state SHALL clear ifid_valid next cycle, discard any same-cycle imem_ack data, and force state REQ.
REQ-013 redirect SHALL take priority over stall and imem_ack when simultaneous.
REQ-014 Fetch latency: first instruction visible on ifid_* one cycle after the ack cycle; one instruction per cycle sustained when imem_ack held 1 and stall 0.

Reset
REQ-015 reset=1 SHALL force state IDLE, ifid_valid=0, ifid_instr=0, ifid_pc=0, fetch_fault=0, imem_req=0, next_pc=0.
REQ-016 reset mid-request SHALL abandon the request; an imem_ack during reset is ignored.

Configuration
REQ-017 Macro FETCH_ALIGN_CHECK_EN defined: pc[0]=1 in REQ SHALL suppress imem_req, set fetch_fault sticky (held until redirect or reset), hold next_pc=pc.
REQ-018 Macro undefined: imem_addr SHALL be {pc[ADDR_W-1:1],1'b0}, fetch_fault tied 0.

Structure
REQ-019 Package fetch_pkg SHALL hold FSM state typedef, ADDR_W/INSTR_W defaults, PC_STEP default.
REQ-020 IF/ID register SHALL be sub-module ifid_reg (load, clear, hold controls).

Verification
REQ-021 reset 3 cycles, pc=0 -> all outputs 0, state IDLE then REQ; imem_addr=0x0000.
REQ-022 pc=0x0004, imem_ack=1, rdata=0xA1B2, stall=0 -> next_pc=0x0006; next cycle ifid_instr=0xA1B2, ifid_pc=0x0004, ifid_valid=1.
REQ-023 ack with stall=1 for 3 cycles -> imem_req=0, ifid_* frozen, next_pc=pc; stall release -> REQ, fetch resumes at same pc.
REQ-024 redirect=1, target=0x0100 with simultaneous imem_ack -> next_pc=0x0100, ifid_valid=0 next cycle, ack data not loaded.
REQ-025 pc=0xFFFE, ack=1 -> next_pc=0x0000.
REQ-026 FETCH_ALIGN_CHECK_EN, pc=0x0003 -> fetch_fault=1, imem_req=0 until redirect to 0x0010; undefined -> imem_addr=0x0002, fetch_fault=0.
